// File: rtl/scan_mux_pkg.sv
// Shared constants and the select-width helper for the scan mux register.
package scan_mux_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 2;

    // Select width: enough bits to index every channel, never less than one.
    function automatic int sel_w(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/scan_mux_reg_if.sv
// Data/control bundle between a driver and the scan mux register.
interface scan_mux_reg_if
    import scan_mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int SEL_W = sel_w(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel;
    logic                      sel_load;
    logic                      scan_en;
    logic                      load;
    logic                      strobe_n;
    logic [WIDTH-1:0]          y;
    logic [SEL_W-1:0]          cur_sel;
    logic                      wrap;
    logic                      q_valid;

    modport master (
        output data_in, sel, sel_load, scan_en, load, strobe_n,
        input  y, cur_sel, wrap, q_valid
    );

    modport slave (
        input  data_in, sel, sel_load, scan_en, load, strobe_n,
        output y, cur_sel, wrap, q_valid
    );

endinterface

// File: rtl/scan_mux_sel_ctr.sv
// Select register: clamped load, wrapping scan increment and wrap pulse.
module scan_mux_sel_ctr
    import scan_mux_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int SEL_W    = sel_w(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_load,
    input  logic             scan_en,
    output logic [SEL_W-1:0] cur_sel,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] sel_nxt;
    logic             wrap_nxt;

    // Next select value: a load beats a scan and never counts as a wrap.
    always_comb begin
        sel_nxt  = cur_sel;
        wrap_nxt = 1'b0;
        if (sel_load) begin
            sel_nxt = (sel > LAST) ? LAST : sel;
        end else if (scan_en) begin
            if (cur_sel == LAST) begin
                sel_nxt  = '0;
                wrap_nxt = 1'b1;
            end else begin
                sel_nxt = cur_sel + SEL_W'(1);
            end
        end
    end

    // Select register and registered one-cycle wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel <= '0;
            wrap    <= 1'b0;
        end else begin
            cur_sel <= sel_nxt;
            wrap    <= wrap_nxt;
        end
    end

endmodule

// File: rtl/scan_mux_reg.sv
// Channel mux feeding a load-enabled output register with strobe gating.
module scan_mux_reg
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int SEL_W    = sel_w(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    scan_mux_reg_if.slave bus
);

    logic [SEL_W-1:0] cur_sel;
    logic [WIDTH-1:0] picked;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;

    scan_mux_sel_ctr #(.CHANNELS(CHANNELS)) u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (bus.sel),
        .sel_load (bus.sel_load),
        .scan_en  (bus.scan_en),
        .cur_sel  (cur_sel),
        .wrap     (bus.wrap)
    );

    // Channel mux driven by the pre-edge select value.
    always_comb begin
        picked = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cur_sel == SEL_W'(k)) picked = bus.data_in[k*WIDTH +: WIDTH];
        end
    end

    // Output register and sticky capture flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.load) begin
            out_q   <= picked;
            valid_q <= 1'b1;
        end
    end

    // Strobe only masks the visible output; stored state is untouched.
    assign bus.y       = bus.strobe_n ? '0 : out_q;
    assign bus.cur_sel = cur_sel;
    assign bus.q_valid = valid_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Directed plus randomized checks of scan_mux_reg at 2 and 3 channels.
module tb_scan_mux_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    scan_mux_reg_if #(.WIDTH(4), .CHANNELS(2)) b2 ();
    scan_mux_reg_if #(.WIDTH(4), .CHANNELS(3)) b3 ();

    scan_mux_reg #(.WIDTH(4), .CHANNELS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    scan_mux_reg #(.WIDTH(4), .CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the 3-channel instance.
    int m_sel, m_out, m_wrap, m_valid;

    initial begin
        b2.data_in = '0; b2.sel = '0; b2.sel_load = 0; b2.scan_en = 0; b2.load = 0; b2.strobe_n = 0;
        b3.data_in = '0; b3.sel = '0; b3.sel_load = 0; b3.scan_en = 0; b3.load = 0; b3.strobe_n = 0;

        // Reset state, with controls active that must be ignored.
        b3.scan_en = 1; b3.load = 1; b3.data_in = 12'hFFF;
        #12;
        check("rst_y", 32'(b3.y), 0);
        check("rst_cur_sel", 32'(b3.cur_sel), 0);
        check("rst_wrap", 32'(b3.wrap), 0);
        check("rst_q_valid", 32'(b3.q_valid), 0);
        b3.scan_en = 0; b3.load = 0; b3.data_in = '0;
        rst_n = 1;

        // Two channels: select channel 1 then capture it.
        b2.data_in = 8'hA5; b2.sel = 1'b1; b2.sel_load = 1;
        tick();
        check("c2_sel_loaded", 32'(b2.cur_sel), 1);
        check("c2_no_valid_yet", 32'(b2.q_valid), 0);
        b2.sel_load = 0; b2.load = 1;
        #2;
        check("c2_y_before_edge", 32'(b2.y), 0);
        tick();
        b2.load = 0;
        check("c2_y_captured", 32'(b2.y), 32'hA);
        check("c2_q_valid", 32'(b2.q_valid), 1);

        // Three channels: scan 4 edges from 0.
        b3.scan_en = 1;
        tick(); check("scan1_sel", 32'(b3.cur_sel), 1); check("scan1_wrap", 32'(b3.wrap), 0);
        tick(); check("scan2_sel", 32'(b3.cur_sel), 2); check("scan2_wrap", 32'(b3.wrap), 0);
        tick(); check("scan3_sel", 32'(b3.cur_sel), 0); check("scan3_wrap", 32'(b3.wrap), 1);
        tick(); check("scan4_sel", 32'(b3.cur_sel), 1); check("scan4_wrap", 32'(b3.wrap), 0);
        b3.scan_en = 0;

        // Clamp, then load beating scan from the last channel.
        b3.sel = 2'd3; b3.sel_load = 1;
        tick(); check("clamp_sel", 32'(b3.cur_sel), 2);
        b3.sel = 2'd0; b3.scan_en = 1;
        tick(); check("load_over_scan_sel", 32'(b3.cur_sel), 0);
        check("load_over_scan_wrap", 32'(b3.wrap), 0);
        b3.sel_load = 0; b3.scan_en = 0;

        // Capture and scan on the same edge take the pre-edge channel.
        b3.data_in = 12'h0C3; b3.load = 1; b3.scan_en = 1;
        tick(); check("cap_scan_y", 32'(b3.y), 3); check("cap_scan_sel", 32'(b3.cur_sel), 1);
        b3.scan_en = 0;
        b3.data_in = 12'h0F3;
        tick(); check("cap_f_y", 32'(b3.y), 32'hF);
        b3.load = 0;
        b3.data_in = 12'h000;
        tick(); check("hold_y", 32'(b3.y), 32'hF);

        // Strobe gating is combinational.
        #2 b3.strobe_n = 1;
        #1 check("strobe_off_y", 32'(b3.y), 0);
        b3.strobe_n = 0;
        #1 check("strobe_on_y", 32'(b3.y), 32'hF);

        // Async reset mid-scan, between edges.
        tick();
        b3.scan_en = 1;
        tick();
        #3 rst_n = 0;
        #1;
        check("arst_cur_sel", 32'(b3.cur_sel), 0);
        check("arst_y", 32'(b3.y), 0);
        check("arst_wrap", 32'(b3.wrap), 0);
        check("arst_q_valid", 32'(b3.q_valid), 0);
        #1 rst_n = 1;
        tick();
        check("post_rst_sel", 32'(b3.cur_sel), 1);
        check("post_rst_y", 32'(b3.y), 0);
        m_sel = 1; m_out = 0; m_wrap = 0; m_valid = 0;

        // Randomized traffic against the arithmetic model.
        for (int i = 0; i < 300; i++) begin
            logic [11:0] d;
            int sv, sl, se, ld, sn, old;
            d  = 12'($urandom);
            sv = $urandom_range(0, 3);
            sl = ($urandom_range(0, 3) == 0);
            se = $urandom_range(0, 1);
            ld = $urandom_range(0, 1);
            sn = ($urandom_range(0, 3) == 0);
            b3.data_in = d; b3.sel = 2'(sv); b3.sel_load = sl[0];
            b3.scan_en = se[0]; b3.load = ld[0]; b3.strobe_n = sn[0];
            if (i % 40 == 39) begin
                #3 rst_n = 0;
                #1;
                check("rnd_arst_sel", 32'(b3.cur_sel), 0);
                check("rnd_arst_valid", 32'(b3.q_valid), 0);
                check("rnd_arst_y", 32'(b3.y), 0);
                m_sel = 0; m_out = 0; m_wrap = 0; m_valid = 0;
                #1 rst_n = 1;
            end
            tick();
            old = m_sel;
            if (ld != 0) begin
                m_out = (int'(d) >> (4 * old)) & 'hF;
                m_valid = 1;
            end
            m_wrap = 0;
            if (sl != 0) m_sel = (sv > 2) ? 2 : sv;
            else if (se != 0) begin
                m_sel = (old + 1) % 3;
                m_wrap = (m_sel == 0);
            end
            check("rnd_sel", 32'(b3.cur_sel), m_sel);
            check("rnd_wrap", 32'(b3.wrap), m_wrap);
            check("rnd_valid", 32'(b3.q_valid), m_valid);
            check("rnd_y", 32'(b3.y), (sn != 0) ? 0 : m_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_mux_reg.md
SCAN_MUX_REG -- requirements
Module: scan_mux_reg

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel (>=1).
REQ-002 Parameter CHANNELS, default 2, number of mux inputs (>=2).
REQ-003 Derived constant SEL_W = max(1, ceil(log2(CHANNELS))), select width; not overridable.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 data_in  in  CHANNELS*WIDTH  flat inputs; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 sel  in  SEL_W  select value to load.
REQ-008 sel_load  in  1  load sel into select register this edge.
REQ-009 scan_en  in  1  advance select register by one this edge.
REQ-010 load  in  1  capture selected channel into output register this edge.
REQ-011 strobe_n  in  1  active-low output strobe; high forces y to zero.
REQ-012 y  out  WIDTH  gated output register.
REQ-013 cur_sel  out  SEL_W  current select register value.
REQ-014 wrap  out  1  one-cycle pulse after scan wrap-around.
REQ-015 q_valid  out  1  high once any capture has occurred since reset.

Function
REQ-016 Select register SHALL load sel when sel_load=1, regardless of scan_en.
REQ-017 sel >= CHANNELS on a load SHALL load CHANNELS-1 (clamp).
REQ-018 When sel_load=0 and scan_en=1, select register SHALL increment, CHANNELS-1 -> 0 wrap.
REQ-019 wrap SHALL be 1 for exactly the cycle following an edge on which a scan wrap (CHANNELS-1 -> 0) occurred; a sel_load to 0 SHALL NOT assert wrap.
REQ-020 When sel_load=0 and scan_en=0, select register SHALL hold.
REQ-021 On an edge with load=1, output register SHALL capture channel indexed by the select register value before that edge's update.
REQ-022 Capture latency SHALL be one edge: data visible on y after the capturing edge, none before.
REQ-023 Output register SHALL hold when load=0; input changes SHALL NOT reach y without load.
REQ-024 y SHALL equal zero when strobe_n=1, else the output register, combinationally (zero-cycle).
REQ-025 strobe_n SHALL NOT alter the output register, select register, wrap or q_valid.
REQ-026 q_valid SHALL set on the first capturing edge and stay set until reset.
REQ-027 cur_sel SHALL reflect the select register directly (registered, no gating).

Reset
REQ-028 rst_n low SHALL immediately clear select register, output register, wrap and q_valid to 0, independent of clk.
REQ-029 While rst_n low, all control inputs SHALL be ignored; y SHALL read 0.
REQ-030 Reset asserted mid-scan or mid-capture SHALL discard the pending update; first edge with rst_n high SHALL behave per Function from the all-zero state.

Structure
REQ-031 Shared package scan_mux_pkg SHALL hold the select-width function and default WIDTH/CHANNELS constants; no other typedefs.
REQ-032 Select register, clamp and wrap logic SHALL live in sub-module scan_mux_sel_ctr, parametrised by CHANNELS.
REQ-033 Top level SHALL contain only the channel mux, output register, q_valid flag and strobe gating.

Verification
REQ-034 WIDTH=4, CHANNELS=2, data_in={4'hA,4'h5}: sel_load sel=1, then load -> y=4'hA one edge after load, q_valid=1.
REQ-035 CHANNELS=3, scan_en held 4 edges from 0 -> cur_sel 1,2,0,1; wrap high only the cycle cur_sel first reads 0 after 2.
REQ-036 CHANNELS=3, sel_load sel=3 -> cur_sel=2; sel_load and scan_en same edge with sel=0 -> cur_sel=0, wrap=0.
REQ-037 load and scan_en same edge at cur_sel=0, data_in ch0=4'h3, ch1=4'hC -> y=4'h3, cur_sel=1.
REQ-038 Output holding 4'hF: strobe_n=1 -> y=0 same cycle; strobe_n=0 -> y=4'hF, no edge needed.
REQ-039 rst_n pulsed low between edges during scan -> cur_sel, y, wrap, q_valid all 0 before next edge; next scan edge gives cur_sel=1.
